// File: rtl/sram_bist_pkg.sv
// Shared types and per-element tables for the March C- BIST controller.
package sram_bist_pkg;

    localparam int unsigned ELEM_W   = 3;
    localparam int unsigned NUM_ELEM = 6;

    typedef enum logic [ELEM_W-1:0] {
        E0 = 3'd0,
        E1 = 3'd1,
        E2 = 3'd2,
        E3 = 3'd3,
        E4 = 3'd4,
        E5 = 3'd5
    } march_elem_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } bist_state_e;

    // Per-element tables, bit i describes element Ei.
    localparam logic [NUM_ELEM-1:0] ELEM_DOWN     = 6'b111000; // address order high to low
    localparam logic [NUM_ELEM-1:0] ELEM_TWO_OPS  = 6'b011110; // read-then-write at each address
    localparam logic [NUM_ELEM-1:0] ELEM_FIRST_RD = 6'b111110; // first op at an address is a read
    localparam logic [NUM_ELEM-1:0] ELEM_RD_ONE   = 6'b010100; // read expects ~BG
    localparam logic [NUM_ELEM-1:0] ELEM_WR_ONE   = 6'b001010; // write presents ~BG

    // Element following e; E5 folds back to E0 so the sequencer is ready for a rerun.
    function automatic march_elem_e next_elem(input march_elem_e e);
        return (e == E5) ? E0 : march_elem_e'(3'(e) + 3'd1);
    endfunction

endpackage

// File: rtl/sram_bist_addr_gen.sv
// AW-bit up/down address counter with load-to-start and terminal detect.
module sram_bist_addr_gen
    import sram_bist_pkg::*;
#(
    parameter int unsigned AW = 9
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic          en_i,
    input  logic          down_i,
    output logic [AW-1:0] addr_o,
    output logic          last_o
);

    logic [AW-1:0] r_addr;
    logic          r_down;

    // Load restarts at the sweep origin for the new direction; enable steps one address.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr <= '0;
            r_down <= 1'b0;
        end else if (load_i) begin
            r_addr <= down_i ? '1 : '0;
            r_down <= down_i;
        end else if (en_i) begin
            r_addr <= r_down ? (r_addr - AW'(1)) : (r_addr + AW'(1));
        end
    end

    assign addr_o = r_addr;
    assign last_o = r_down ? (r_addr == '0) : (r_addr == '1);

endmodule

// File: rtl/sram_march_bist_ctrl.sv
// March C- BIST initiator for a 1P SRAM BIST port: sequences ops, compares reads, captures first fail.
module sram_march_bist_ctrl
    import sram_bist_pkg::*;
#(
    parameter int unsigned   DW = 32,
    parameter int unsigned   AW = 9,
    parameter logic [DW-1:0] BG = '0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    output logic          bist_en_o,
    output logic          bist_men_o,
    output logic          bist_wen_o,
    output logic          bist_ren_o,
    output logic [AW-1:0] bist_addr_o,
    output logic [DW-1:0] bist_din_o,
    output logic [DW-1:0] bist_bm_o,
    input  logic [DW-1:0] bist_dout_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          fail_o,
    output logic [AW-1:0] fail_addr_o,
    output logic [2:0]    fail_elem_o
);

    bist_state_e r_state, w_state_nxt;

    // Sequencer: the op that will be issued next.
    march_elem_e r_elem, w_elem_nxt;
    logic        r_phase;
    logic [AW-1:0] w_addr;
    logic        w_addr_last;
    logic        w_op_rd, w_op_last, w_elem_last, w_final;
    logic        w_issue, w_launch;

    // Op currently presented to the macro.
    logic          r_active, r_men, r_wen, r_ren;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_din;
    march_elem_e   r_op_elem;

    // Compare stage: read issued last cycle, data on bist_dout_i this cycle.
    logic          r_cmp_vld;
    logic [AW-1:0] r_cmp_addr;
    logic [DW-1:0] r_cmp_exp;
    march_elem_e   r_cmp_elem;

    logic          r_done, r_fail;
    logic [AW-1:0] r_fail_addr;
    march_elem_e   r_fail_elem;

    sram_bist_addr_gen #(.AW(AW)) u_addr_gen (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (w_issue & w_elem_last),
        .en_i   (w_issue & w_op_last & ~w_elem_last),
        .down_i (ELEM_DOWN[w_elem_nxt]),
        .addr_o (w_addr),
        .last_o (w_addr_last)
    );

    // Decode the pending op and detect element / sequence boundaries.
    always_comb begin
        w_op_rd     = ELEM_TWO_OPS[r_elem] ? ~r_phase : ELEM_FIRST_RD[r_elem];
        w_op_last   = ~ELEM_TWO_OPS[r_elem] | r_phase;
        w_elem_last = w_op_last & w_addr_last;
        w_elem_nxt  = next_elem(r_elem);
        w_final     = (r_op_elem == E5) && (r_addr == '0);
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next state and issue control; the first op goes out on the edge that samples start.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_launch    = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start_i) begin
                    w_state_nxt = RUN;
                    w_issue     = 1'b1;
                    w_launch    = 1'b1;
                end
            end
            RUN: begin
                if (w_final) w_state_nxt = DRAIN;
                else         w_issue     = 1'b1;
            end
            DRAIN:   w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Advance element / phase as ops are issued.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_elem  <= E0;
            r_phase <= 1'b0;
        end else if (w_issue) begin
            if (w_op_last) begin
                r_phase <= 1'b0;
                if (w_elem_last) r_elem <= w_elem_nxt;
            end else begin
                r_phase <= 1'b1;
            end
        end
    end

    // Macro port drive; address and write data hold when no op is issued.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_active  <= 1'b0;
            r_men     <= 1'b0;
            r_wen     <= 1'b0;
            r_ren     <= 1'b0;
            r_addr    <= '0;
            r_din     <= '0;
            r_op_elem <= E0;
        end else begin
            r_active <= (w_state_nxt == RUN) || (w_state_nxt == DRAIN);
            r_men    <= w_issue;
            r_wen    <= w_issue & ~w_op_rd;
            r_ren    <= w_issue & w_op_rd;
            if (w_issue) begin
                r_addr    <= w_addr;
                r_op_elem <= r_elem;
                if (!w_op_rd) r_din <= ELEM_WR_ONE[r_elem] ? ~BG : BG;
            end
        end
    end

    // Register the expectation of the read on the port so it lines up with its data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cmp_vld  <= 1'b0;
            r_cmp_addr <= '0;
            r_cmp_exp  <= '0;
            r_cmp_elem <= E0;
        end else begin
            r_cmp_vld  <= r_ren;
            r_cmp_addr <= r_addr;
            r_cmp_exp  <= ELEM_RD_ONE[r_op_elem] ? ~BG : BG;
            r_cmp_elem <= r_op_elem;
        end
    end

    // Sticky done/fail with first-fail capture; cleared when a run launches.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_elem <= E0;
        end else if (w_launch) begin
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_elem <= E0;
        end else begin
            if (r_state == DRAIN) r_done <= 1'b1;
            if (r_cmp_vld && (bist_dout_i != r_cmp_exp)) begin
                r_fail <= 1'b1;
                if (!r_fail) begin
                    r_fail_addr <= r_cmp_addr;
                    r_fail_elem <= r_cmp_elem;
                end
            end
        end
    end

    assign bist_en_o   = r_active;
    assign busy_o      = r_active;
    assign bist_men_o  = r_men;
    assign bist_wen_o  = r_wen;
    assign bist_ren_o  = r_ren;
    assign bist_addr_o = r_addr;
    assign bist_din_o  = r_din;
    assign bist_bm_o   = '1;
    assign done_o      = r_done;
    assign fail_o      = r_fail;
    assign fail_addr_o = r_fail_addr;
    assign fail_elem_o = r_fail_elem;

endmodule

// File: tb/tb_sram_march_bist_ctrl.sv
// Bench: two controllers (BG=0 and BG=A5A5A5A5) on behavioural SRAMs, checked every cycle against an op-index model.
module tb_sram_march_bist_ctrl;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 9;
    localparam int          N    = 1 << AW;
    localparam int          NOPS = 10 * N;

    logic clk = 1'b0;
    logic rst_n;
    logic start;

    logic [1:0]          en, men, wen, ren, busy, done, fail;
    logic [1:0][AW-1:0]  addr, faddr;
    logic [1:0][DW-1:0]  din, bm, dout;
    logic [1:0][2:0]     felem;

    logic [DW-1:0] mem [2][N];

    // Fault injection, applied to instance 0 only.
    bit            sa_en, flip_en;
    logic [AW-1:0] sa_addr, flip_addr;
    int            sa_bit;
    logic          sa_val;
    int            cur_elem [2];

    // Reference model state.
    int            m_cyc   [2];
    bit            m_done  [2], m_fail [2], p_vld [2];
    logic [AW-1:0] m_addr  [2], m_faddr [2], p_addr [2];
    logic [2:0]    m_felem [2], p_elem [2];
    logic [DW-1:0] m_din   [2];
    logic [DW-1:0] bgv     [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_march_bist_ctrl #(.DW(DW), .AW(AW), .BG(32'h0000_0000)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start),
        .bist_en_o(en[0]), .bist_men_o(men[0]), .bist_wen_o(wen[0]), .bist_ren_o(ren[0]),
        .bist_addr_o(addr[0]), .bist_din_o(din[0]), .bist_bm_o(bm[0]), .bist_dout_i(dout[0]),
        .busy_o(busy[0]), .done_o(done[0]), .fail_o(fail[0]),
        .fail_addr_o(faddr[0]), .fail_elem_o(felem[0])
    );

    sram_march_bist_ctrl #(.DW(DW), .AW(AW), .BG(32'hA5A5_A5A5)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start),
        .bist_en_o(en[1]), .bist_men_o(men[1]), .bist_wen_o(wen[1]), .bist_ren_o(ren[1]),
        .bist_addr_o(addr[1]), .bist_din_o(din[1]), .bist_bm_o(bm[1]), .bist_dout_i(dout[1]),
        .busy_o(busy[1]), .done_o(done[1]), .fail_o(fail[1]),
        .fail_addr_o(faddr[1]), .fail_elem_o(felem[1])
    );

    function automatic logic [DW-1:0] faulty(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = d;
        if (i == 0 && sa_en && a == sa_addr) r[sa_bit] = sa_val;
        if (i == 0 && flip_en && a == flip_addr && cur_elem[0] == 4) r = ~r;
        return r;
    endfunction

    // Behavioural SRAM: masked write, read data valid the cycle after the read.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (men[i] && wen[i]) mem[i][addr[i]] <= (mem[i][addr[i]] & ~bm[i]) | (din[i] & bm[i]);
            if (men[i] && ren[i]) dout[i] <= faulty(i, addr[i], mem[i][addr[i]]);
        end
    end

    // March C- op number k: element, address, write?, data (write value or expected read value).
    function automatic void op_of(input int k, input logic [DW-1:0] bg, output int e,
                                  output logic [AW-1:0] a, output bit w, output logic [DW-1:0] d);
        int j;
        if (k < N) begin
            e = 0; a = AW'(k); w = 1'b1; d = bg;
        end else if (k < 9 * N) begin
            e = 1 + (k - N) / (2 * N);
            j = (k - N) % (2 * N);
            a = (e <= 2) ? AW'(j / 2) : AW'(N - 1 - j / 2);
            w = (j % 2) == 1;
            d = (((e % 2) == 1) ^ w) ? bg : ~bg;
        end else begin
            e = 5; a = AW'(N - 1 - (k - 9 * N)); w = 1'b0; d = bg;
        end
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // One clock: advance the model over the edge just passed, compare every output.
    task automatic tick();
        int            e;
        logic [AW-1:0] a;
        bit            w, op, run;
        logic [DW-1:0] d;
        logic [6:0]    ce, cg;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_cyc[i] = -1; m_done[i] = 0; m_fail[i] = 0; p_vld[i] = 0;
                m_faddr[i] = '0; m_felem[i] = '0; m_addr[i] = '0; m_din[i] = '0;
            end else begin
                if (p_vld[i]) begin
                    if (!m_fail[i]) begin
                        m_faddr[i] = p_addr[i];
                        m_felem[i] = p_elem[i];
                    end
                    m_fail[i] = 1;
                    p_vld[i]  = 0;
                end
                if (m_cyc[i] >= 0) begin
                    m_cyc[i]++;
                    if (m_cyc[i] > NOPS) begin
                        m_cyc[i]  = -1;
                        m_done[i] = 1;
                    end
                end else if (start) begin
                    m_cyc[i] = 0; m_done[i] = 0; m_fail[i] = 0;
                    m_faddr[i] = '0; m_felem[i] = '0;
                end
            end
            run = m_cyc[i] >= 0;
            op  = run && (m_cyc[i] < NOPS);
            w   = 1'b0;
            if (op) begin
                op_of(m_cyc[i], bgv[i], e, a, w, d);
                m_addr[i]   = a;
                cur_elem[i] = e;
                if (w) m_din[i] = d;
            end
            ce = {run, run, op, op && w, op && !w, m_done[i], m_fail[i]};
            cg = {en[i], busy[i], men[i], wen[i], ren[i], done[i], fail[i]};
            chk($sformatf("ctl%0d c=%0d", i, m_cyc[i]), 64'(cg), 64'(ce));
            chk($sformatf("addr%0d c=%0d", i, m_cyc[i]), 64'(addr[i]), 64'(m_addr[i]));
            chk($sformatf("din%0d c=%0d", i, m_cyc[i]), 64'(din[i]), 64'(m_din[i]));
            chk($sformatf("cap%0d c=%0d", i, m_cyc[i]), 64'({faddr[i], felem[i]}),
                64'({m_faddr[i], m_felem[i]}));
            chk($sformatf("bm%0d", i), 64'(bm[i]), 64'(32'hFFFF_FFFF));
            // Data for the read issued in the previous cycle is on dout now.
            if (m_cyc[i] >= 1 && m_cyc[i] <= NOPS) begin
                op_of(m_cyc[i] - 1, bgv[i], e, a, w, d);
                if (!w && dout[i] !== d) begin
                    p_vld[i]  = 1;
                    p_addr[i] = a;
                    p_elem[i] = 3'(e);
                end
            end
        end
    endtask

    // Launch a run and clock until done (bounded); n is the cycle on which done is seen.
    task automatic run_test(input int ign_at, input bit restart, output int n);
        start = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            start = (n == ign_at);
            if (n == 1) begin
                chk("bg_e0_w0", 64'(din[1]), 64'(32'hA5A5_A5A5));
                if (restart) chk("restart_clear", 64'({done[0], fail[0]}), 64'(0));
            end
            if (n == N + 2) chk("bg_e1_w1", 64'(din[1]), 64'(32'h5A5A_5A5A));
        end while (!done[0] && n < 6000);
        start = 1'b0;
    endtask

    initial begin
        int n;
        bgv[0] = 32'h0000_0000;
        bgv[1] = 32'hA5A5_A5A5;
        sa_en = 0; flip_en = 0; sa_addr = '0; flip_addr = '0; sa_bit = 0; sa_val = 0;
        cur_elem[0] = 0; cur_elem[1] = 0;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) tick();
        chk("rst_ctl", 64'({en, men, wen, ren, busy, done, fail}), 64'(0));
        chk("rst_bm", 64'(bm[0]), 64'(32'hFFFF_FFFF));
        rst_n = 1'b1;
        repeat (2) tick();

        // Fault-free run; a start in the middle of RUN must be ignored.
        run_test(300, 1'b0, n);
        chk("latency_clean", 64'(n), 64'(5122));
        chk("clean_fail", 64'(fail), 64'(0));
        repeat (3) tick();

        // Stuck-at-1 on bit 3 of 0x05A: first seen by the r0 of E1.
        sa_en = 1; sa_addr = 9'h05A; sa_bit = 3; sa_val = 1'b1;
        run_test(-1, 1'b0, n);
        chk("latency_sa1", 64'(n), 64'(5122));
        chk("sa1_fail", 64'(fail[0]), 64'(1));
        chk("sa1_addr", 64'(faddr[0]), 64'(9'h05A));
        chk("sa1_elem", 64'(felem[0]), 64'(1));
        chk("bg_pass", 64'(fail[1]), 64'(0));
        tick();
        chk("done_sticky", 64'({done[0], fail[0]}), 64'(2'b11));

        // Start from DONE; 0x010 SA0 bit0 (caught in E2) precedes 0x1F0 flip in E4.
        sa_addr = 9'h010; sa_bit = 0; sa_val = 1'b0;
        flip_en = 1; flip_addr = 9'h1F0;
        run_test(-1, 1'b1, n);
        chk("latency_two", 64'(n), 64'(5122));
        chk("two_fail", 64'(fail[0]), 64'(1));
        chk("two_addr", 64'(faddr[0]), 64'(9'h010));
        chk("two_elem", 64'(felem[0]), 64'(2));
        sa_en = 0; flip_en = 0;
        tick();

        // Reset 1000 cycles into RUN: outputs drop without waiting for a clock.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (1000) tick();
        chk("pre_rst_busy", 64'({en[0], busy[0]}), 64'(2'b11));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ctl", 64'({en, men, wen, ren, busy, done, fail}), 64'(0));
        chk("arst_data", 64'({addr, faddr, felem}), 64'(0));
        chk("arst_din", 64'({din[0] | din[1]}), 64'(0));
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        run_test(-1, 1'b0, n);
        chk("latency_after_rst", 64'(n), 64'(5122));
        chk("after_rst_pass", 64'({done, fail}), 64'(4'b1100));
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
